// File: rtl/power_spectrum_avg_if.sv
// AXI-Stream style channel used for both the FFT-bin input and the averaged-power output.
interface power_spectrum_avg_if #(
    parameter int W = 32
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/power_spectrum_avg.sv
// Streaming |X|^2 detector: Re^2+Im^2 per FFT bin, accumulated over 2^AVG_LOG2 frames
// in a per-bin RAM, emitting one truncated average frame per averaging period.
module power_spectrum_avg #(
    parameter int DATA_W   = 16,
    parameter int FFT_LEN  = 1024,
    parameter int AVG_LOG2 = 2
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    power_spectrum_avg_if.slave  s_axis,
    power_spectrum_avg_if.master m_axis,
    output logic                 frame_err,
    input  logic                 clr_err
);
    localparam int P_W   = 2 * DATA_W;
    localparam int ACC_W = P_W + AVG_LOG2;
    localparam int BIN_W = $clog2(FFT_LEN);
    localparam int FC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(FFT_LEN - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'((1 << AVG_LOG2) - 1);

    logic                    w_ce;
    logic                    w_accept;
    logic                    r_run;
    logic [BIN_W-1:0]        r_bin_cnt;
    logic [FC_W-1:0]         r_frame_cnt;
    logic [BIN_W-1:0]        w_bin_nxt;
    logic [FC_W-1:0]         w_frame_nxt;
    logic                    w_err_now;
    logic signed [DATA_W-1:0] w_re_n;
    logic signed [DATA_W-1:0] w_im_n;
    logic signed [P_W-1:0]   w_re;
    logic signed [P_W-1:0]   w_im;

    logic                    r1_valid, r1_first, r1_emit, r1_last;
    logic [BIN_W-1:0]        r1_bin;
    logic [P_W-1:0]          r1_re2, r1_im2;

    logic                    r2_valid, r2_first, r2_emit, r2_last;
    logic [BIN_W-1:0]        r2_bin;
    logic [P_W-1:0]          r2_p;
    logic [ACC_W-1:0]        r2_rd;

    logic [ACC_W-1:0]        w_acc_new;
    logic [P_W-1:0]          w_avg;
    logic [ACC_W-1:0]        r_acc_mem [FFT_LEN];

    logic [P_W-1:0]          r_m_tdata;
    logic                    r_m_tvalid;
    logic                    r_m_tlast;
    logic                    r_frame_err;

    // A stalled output register freezes every stage, RAM read port included.
    assign w_ce           = !(r_m_tvalid && !m_axis.tready);
    assign s_axis.tready  = r_run && w_ce;
    assign w_accept       = s_axis.tvalid && r_run && w_ce;
    assign w_re_n         = s_axis.tdata[DATA_W-1:0];
    assign w_im_n         = s_axis.tdata[P_W-1:DATA_W];
    assign w_re           = {{DATA_W{w_re_n[DATA_W-1]}}, w_re_n};
    assign w_im           = {{DATA_W{w_im_n[DATA_W-1]}}, w_im_n};
    assign w_acc_new      = r2_first ? ACC_W'(r2_p) : (r2_rd + ACC_W'(r2_p));
    assign w_avg          = w_acc_new[AVG_LOG2 +: P_W];
    assign m_axis.tdata   = r_m_tdata;
    assign m_axis.tvalid  = r_m_tvalid;
    assign m_axis.tlast   = r_m_tlast;
    assign frame_err      = r_frame_err;

    // Bin/frame counter advance and tlast position checking.
    always_comb begin
        w_bin_nxt   = r_bin_cnt;
        w_frame_nxt = r_frame_cnt;
        w_err_now   = 1'b0;
        if (w_accept) begin
            if (s_axis.tlast && (r_bin_cnt != BIN_LAST)) begin
                w_err_now   = 1'b1;
                w_bin_nxt   = {BIN_W{1'b0}};
                w_frame_nxt = {FC_W{1'b0}};
            end else if (r_bin_cnt == BIN_LAST) begin
                w_err_now   = !s_axis.tlast;
                w_bin_nxt   = {BIN_W{1'b0}};
                w_frame_nxt = (r_frame_cnt == FC_LAST) ? {FC_W{1'b0}} : (r_frame_cnt + FC_W'(1));
            end else begin
                w_bin_nxt   = r_bin_cnt + BIN_W'(1);
            end
        end else begin
            w_err_now   = 1'b0;
        end
    end

    // Counters, sticky error flag and post-reset ready enable.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_run       <= 1'b0;
            r_bin_cnt   <= {BIN_W{1'b0}};
            r_frame_cnt <= {FC_W{1'b0}};
            r_frame_err <= 1'b0;
        end else begin
            r_run       <= 1'b1;
            r_bin_cnt   <= w_bin_nxt;
            r_frame_cnt <= w_frame_nxt;
            if (w_err_now) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end else begin
                r_frame_err <= r_frame_err;
            end
        end
    end

    // S1: squares, bin address and per-sample frame flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r1_valid <= 1'b0;
            r1_first <= 1'b0;
            r1_emit  <= 1'b0;
            r1_last  <= 1'b0;
            r1_bin   <= {BIN_W{1'b0}};
            r1_re2   <= {P_W{1'b0}};
            r1_im2   <= {P_W{1'b0}};
        end else if (w_ce) begin
            r1_valid <= w_accept;
            r1_first <= (r_frame_cnt == {FC_W{1'b0}});
            r1_emit  <= (r_frame_cnt == FC_LAST);
            r1_last  <= (r_bin_cnt == BIN_LAST);
            r1_bin   <= r_bin_cnt;
            r1_re2   <= $unsigned(w_re * w_re);
            r1_im2   <= $unsigned(w_im * w_im);
        end
    end

    // S2: power sum; the sum of two squares never exceeds 2^(P_W-1), so P_W bits suffice.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r2_valid <= 1'b0;
            r2_first <= 1'b0;
            r2_emit  <= 1'b0;
            r2_last  <= 1'b0;
            r2_bin   <= {BIN_W{1'b0}};
            r2_p     <= {P_W{1'b0}};
        end else if (w_ce) begin
            r2_valid <= r1_valid;
            r2_first <= r1_first;
            r2_emit  <= r1_emit;
            r2_last  <= r1_last;
            r2_bin   <= r1_bin;
            r2_p     <= r1_re2 + r1_im2;
        end
    end

    // Per-bin accumulator RAM: read issued from S1, read-modify-write completes in S3.
    always_ff @(posedge aclk) begin
        if (w_ce) begin
            r2_rd <= r_acc_mem[r1_bin];
            if (r2_valid) begin
                r_acc_mem[r2_bin] <= w_acc_new;
            end
        end
    end

    // S3 output register, held stable while the downstream stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= {P_W{1'b0}};
        end else if (w_ce) begin
            r_m_tvalid <= r2_valid && r2_emit;
            if (r2_valid && r2_emit) begin
                r_m_tdata <= w_avg;
                r_m_tlast <= r2_last;
            end else begin
                r_m_tdata <= r_m_tdata;
                r_m_tlast <= 1'b0;
            end
        end
    end
endmodule
